// File: rtl/rx_oversample.sv
// rx_oversample
// Oversampling UART-style receiver. A frame is a start bit (0), DATA_W data
// bits LSB first, an even-parity bit and a stop bit (1). The serial line is
// synchronised, the start bit is qualified at its middle, and each following
// bit is decided by a 2-of-3 majority of the last three samples in its slot.
//
// Ports
//   clk          sole clock, rising edge
//   rst          asynchronous active-high reset
//   en           clock enable; all state holds while low
//   rx_si        serial input, idle high, asynchronous to clk
//   rx_data_ack  consumer acknowledge of the presented word
//   rx_po        received parallel word
//   rx_busy      frame reception in progress
//   rx_ready     rx_po holds an unacknowledged word
//   rx_error     parity or stop-bit error on the presented word
//   rx_overrun   a frame was dropped while rx_ready was high
module rx_oversample #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              rx_si,
  input  logic              rx_data_ack,
  output logic [DATA_W-1:0] rx_po,
  output logic              rx_busy,
  output logic              rx_ready,
  output logic              rx_error,
  output logic              rx_overrun
);

  localparam int CNT_W  = $clog2(OVERSAMPLE);
  localparam int BITN_W = $clog2(DATA_W + 1);

  localparam logic [CNT_W-1:0]  CNT_HALF  = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0]  CNT_S0    = CNT_W'(OVERSAMPLE - 3);
  localparam logic [CNT_W-1:0]  CNT_S1    = CNT_W'(OVERSAMPLE - 2);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(OVERSAMPLE - 1);
  localparam logic [BITN_W-1:0] BITN_LAST = BITN_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [BITN_W-1:0]   r_bitn;
  logic [DATA_W-1:0]   r_shift;
  logic                r_parity;
  logic [1:0]          r_samp;

  // Two-flop synchroniser plus one more stage for falling-edge detection.
  logic                r_sync1;
  logic                r_s;
  logic                r_sPrev;

  logic [DATA_W-1:0]   r_po;
  logic                r_busy;
  logic                r_ready;
  logic                r_error;
  logic                r_overrun;

  logic                w_bit;
  logic                w_parErr;

  // The third sample is the live synchronised value on the decision cycle.
  assign w_bit    = (r_samp[0] & r_samp[1]) | (r_samp[0] & r_s) | (r_samp[1] & r_s);
  assign w_parErr = ^{r_shift, r_parity};

  assign rx_po      = r_po;
  assign rx_busy    = r_busy;
  assign rx_ready   = r_ready;
  assign rx_error   = r_error;
  assign rx_overrun = r_overrun;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_bitn    <= '0;
      r_shift   <= '0;
      r_parity  <= 1'b0;
      r_samp    <= '0;
      r_sync1   <= 1'b1;
      r_s       <= 1'b1;
      r_sPrev   <= 1'b1;
      r_po      <= '0;
      r_busy    <= 1'b0;
      r_ready   <= 1'b0;
      r_error   <= 1'b0;
      r_overrun <= 1'b0;
    end else if (en) begin
      r_sync1 <= rx_si;
      r_s     <= r_sync1;
      r_sPrev <= r_s;

      // Acknowledge clears the flags; a completion later in this block
      // overrides these assignments, so ack is effectively handled first.
      if (rx_data_ack && r_ready) begin
        r_ready   <= 1'b0;
        r_error   <= 1'b0;
        r_overrun <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          if (!r_s && r_sPrev) begin
            r_state <= START;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end

        // Re-check the line at mid start bit to reject glitches.
        START: begin
          if (r_cnt == CNT_HALF) begin
            r_cnt <= '0;
            if (r_s) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_bitn  <= '0;
              r_state <= DATA;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        DATA, PARITY, STOP: begin
          if (r_cnt == CNT_S0) begin
            r_samp[0] <= r_s;
          end
          if (r_cnt == CNT_S1) begin
            r_samp[1] <= r_s;
          end
          if (r_cnt == CNT_LAST) begin
            r_cnt <= '0;
            if (r_state == DATA) begin
              r_shift <= {w_bit, r_shift[DATA_W-1:1]};
              r_bitn  <= r_bitn + 1'b1;
              if (r_bitn == BITN_LAST) begin
                r_state <= PARITY;
              end
            end else if (r_state == PARITY) begin
              r_parity <= w_bit;
              r_state  <= STOP;
            end else begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
              // A word is loaded if the slot is free or being freed now.
              if (!r_ready || rx_data_ack) begin
                r_po      <= r_shift;
                r_error   <= w_parErr | ~w_bit;
                r_ready   <= 1'b1;
                r_overrun <= 1'b0;
              end else begin
                r_overrun <= 1'b1;
              end
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rx_oversample.sv
// tb_rx_oversample
// Directed bench for rx_oversample: sends hand-built frames on rx_si and
// compares the presented word and flags against hand-computed constants.
module tb_rx_oversample;

  localparam int OS = 16;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          rx_si;
  logic          rx_data_ack;
  logic [DW-1:0] rx_po;
  logic          rx_busy;
  logic          rx_ready;
  logic          rx_error;
  logic          rx_overrun;

  int checkCount = 0;
  int errorCount = 0;
  int busyCnt;

  rx_oversample #(
    .OVERSAMPLE(OS),
    .DATA_W    (DW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .rx_si      (rx_si),
    .rx_data_ack(rx_data_ack),
    .rx_po      (rx_po),
    .rx_busy    (rx_busy),
    .rx_ready   (rx_ready),
    .rx_error   (rx_error),
    .rx_overrun (rx_overrun)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drives the first nBits bits of a frame, OS clocks per bit. ackAt selects
  // the loop cycle on which rx_data_ack is high (-1 for none).
  task automatic applyStimulus(input logic [7:0] data, input logic parity, input logic stop,
                               input int nBits, input int ackAt);
    logic [10:0] frame;
    frame = {stop, parity, data, 1'b0};
    for (int k = 0; k < nBits * OS; k++) begin
      rx_si       = frame[k / OS];
      rx_data_ack = (k == ackAt);
      @(posedge clk);
      #1;
    end
    rx_data_ack = 1'b0;
    if (nBits == 11) rx_si = 1'b1;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulseAck();
    rx_data_ack = 1'b1;
    @(posedge clk);
    #1;
    rx_data_ack = 1'b0;
  endtask

  initial begin
    rst         = 1'b1;
    en          = 1'b1;
    rx_si       = 1'b1;
    rx_data_ack = 1'b0;
    idleCycles(3);
    checkOutput("reset_po",      32'(rx_po),   32'h00);
    checkOutput("reset_busy",    32'(rx_busy), 32'h0);
    checkOutput("reset_ready",   32'(rx_ready), 32'h0);
    checkOutput("reset_error",   32'(rx_error), 32'h0);
    checkOutput("reset_overrun", 32'(rx_overrun), 32'h0);
    rst = 1'b0;
    idleCycles(10);

    // Good frame 0xA5, then acknowledge.
    applyStimulus(8'hA5, 1'b0, 1'b1, 11, -1);
    checkOutput("a5_po",    32'(rx_po),    32'hA5);
    checkOutput("a5_ready", 32'(rx_ready), 32'h1);
    checkOutput("a5_error", 32'(rx_error), 32'h0);
    checkOutput("a5_busy",  32'(rx_busy),  32'h0);
    pulseAck();
    checkOutput("a5_ack_ready", 32'(rx_ready), 32'h0);
    idleCycles(5);

    // Bad parity on 0x77.
    applyStimulus(8'h77, 1'b1, 1'b1, 11, -1);
    checkOutput("p77_po",    32'(rx_po),    32'h77);
    checkOutput("p77_ready", 32'(rx_ready), 32'h1);
    checkOutput("p77_error", 32'(rx_error), 32'h1);
    pulseAck();
    checkOutput("p77_ack_error", 32'(rx_error), 32'h0);
    idleCycles(5);

    // Correct parity on 0x10 but stop bit 0.
    applyStimulus(8'h10, 1'b1, 1'b0, 11, -1);
    checkOutput("s10_po",    32'(rx_po),    32'h10);
    checkOutput("s10_error", 32'(rx_error), 32'h1);
    checkOutput("s10_busy",  32'(rx_busy),  32'h0);
    pulseAck();
    idleCycles(20);

    // Start glitch: 4 clocks low, busy for the half-bit qualify window only.
    busyCnt = 0;
    rx_si   = 1'b0;
    for (int i = 1; i <= 24; i++) begin
      @(posedge clk);
      #1;
      if (i == 4) rx_si = 1'b1;
      if (rx_busy) busyCnt++;
    end
    checkOutput("glitch_busy_cycles", 32'(busyCnt), 32'd8);
    checkOutput("glitch_ready",       32'(rx_ready), 32'h0);
    checkOutput("glitch_busy_end",    32'(rx_busy),  32'h0);
    idleCycles(5);

    // Two frames without ack: second is dropped.
    applyStimulus(8'hEF, 1'b1, 1'b1, 11, -1);
    checkOutput("ef_po",      32'(rx_po),      32'hEF);
    checkOutput("ef_overrun", 32'(rx_overrun), 32'h0);
    applyStimulus(8'hA9, 1'b0, 1'b1, 11, -1);
    checkOutput("a9_po",      32'(rx_po),      32'hEF);
    checkOutput("a9_overrun", 32'(rx_overrun), 32'h1);
    checkOutput("a9_ready",   32'(rx_ready),   32'h1);
    checkOutput("a9_error",   32'(rx_error),   32'h0);
    pulseAck();
    checkOutput("ovr_ack_ready",   32'(rx_ready),   32'h0);
    checkOutput("ovr_ack_overrun", 32'(rx_overrun), 32'h0);
    idleCycles(5);

    // Ack coincides with the stop-bit decision (loop cycle 170).
    applyStimulus(8'h3C, 1'b0, 1'b1, 11, -1);
    checkOutput("c3_po", 32'(rx_po), 32'h3C);
    applyStimulus(8'h5A, 1'b0, 1'b1, 11, 170);
    checkOutput("same_po",      32'(rx_po),      32'h5A);
    checkOutput("same_ready",   32'(rx_ready),   32'h1);
    checkOutput("same_overrun", 32'(rx_overrun), 32'h0);
    checkOutput("same_error",   32'(rx_error),   32'h0);
    pulseAck();
    idleCycles(5);

    // With en low a falling edge is not seen.
    en    = 1'b0;
    rx_si = 1'b0;
    idleCycles(30);
    checkOutput("en_low_busy", 32'(rx_busy), 32'h0);
    rx_si = 1'b1;
    idleCycles(3);
    en = 1'b1;
    idleCycles(10);

    // Reset during data bit 3 of 0xA5, then a clean 0x10 frame.
    applyStimulus(8'hA5, 1'b0, 1'b1, 4, -1);
    rx_si = 1'b0;
    idleCycles(8);
    checkOutput("mid_busy", 32'(rx_busy), 32'h1);
    rst   = 1'b1;
    rx_si = 1'b1;
    #1;
    checkOutput("mid_rst_po",    32'(rx_po),    32'h00);
    checkOutput("mid_rst_busy",  32'(rx_busy),  32'h0);
    checkOutput("mid_rst_ready", 32'(rx_ready), 32'h0);
    idleCycles(3);
    rst = 1'b0;
    idleCycles(10);
    checkOutput("post_rst_busy", 32'(rx_busy), 32'h0);
    applyStimulus(8'h10, 1'b1, 1'b1, 11, -1);
    checkOutput("post_rst_po",    32'(rx_po),    32'h10);
    checkOutput("post_rst_ready", 32'(rx_ready), 32'h1);
    checkOutput("post_rst_error", 32'(rx_error), 32'h0);
    idleCycles(5);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
